display_scan_controller: RTL and testbench

Time-multiplexes four 7-segment digit patterns (two operand digits, two sum digits) onto one shared segment bus and four digit-select lines. It replaces free-running digit selection with a prescaled scan FSM, an inter-digit blanking interval against ghosting, and a double-buffered load handshake so displayed values change only at frame boundaries. It sits between the four segment encoders and the board pins.

---
 rtl/display_pkg.sv | 20 ++
 rtl/display_scan_controller_if.sv | 25 ++
 rtl/scan_prescaler.sv | 43 ++++
 rtl/display_scan_controller.sv | 125 ++++++++++++
 tb/tb_display_scan_controller.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared constants, segment type and scan-state enum for the display scan controller.
package display_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam int         IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [6:0] SEG_ZERO   = 7'b1111110;
    localparam logic [6:0] SEG_OFF    = 7'b0000000;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_e;

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
        return NUM_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Bundle between the segment encoders (master) and the scan controller (slave).
interface display_scan_controller_if;
    import display_pkg::*;

    logic                  load;
    seg_t                  disp0;
    seg_t                  disp1;
    seg_t                  disp2;
    seg_t                  disp3;
    seg_t                  seg;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  ack;
    logic                  frame_done;

    modport master (
        output load, disp0, disp1, disp2, disp3,
        input  seg, digit_sel, ack, frame_done
    );

    modport slave (
        input  load, disp0, disp1, disp2, disp3,
        output seg, digit_sel, ack, frame_done
    );

endinterface

// File: rtl/scan_prescaler.sv
// Slot prescaler and digit-index counter; flags the last cycle of every slot and frame.
module scan_prescaler
    import display_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [CNT_W-1:0] cnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             slot_end_o,
    output logic             frame_end_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_end;
    logic             frame_end;

    always_comb begin
        slot_end  = (cnt_q == CNT_W'(DIV - 1));
        frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = slot_end ? idx_q + 1'b1 : idx_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign idx_o       = idx_q;
    assign slot_end_o  = slot_end;
    assign frame_end_o = frame_end;

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed 7-segment scan with blanking and frame-synchronous double buffering.
// Optional leading-zero suppression is built when ZERO_BLANK_EN is defined.
module display_scan_controller #(
    parameter int DIV   = 50000,
    parameter int BLANK = 1000
) (
    input  logic                        Clock,
    input  logic                        Resetn,
    display_scan_controller_if.slave    bus
);
    import display_pkg::*;

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0]                cnt;
    logic [IDX_W-1:0]                idx;
    logic                            slot_end;
    logic                            frame_end;

    scan_state_e                     state_q, state_d;
    logic [NUM_DIGITS-1:0][6:0]      active_q, active_d;
    logic [NUM_DIGITS-1:0][6:0]      pending_q, pending_d;
    logic                            pend_q, pend_d;
    logic                            commit;

    seg_t                            seg_q, seg_d;
    logic [NUM_DIGITS-1:0]           sel_q, sel_d;
    logic                            ack_q, ack_d;
    logic                            frame_done_q, frame_done_d;

    scan_prescaler #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk_i       (Clock),
        .rst_ni      (Resetn),
        .cnt_o       (cnt),
        .idx_o       (idx),
        .slot_end_o  (slot_end),
        .frame_end_o (frame_end)
    );

`ifdef ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] dark;

    // A digit goes dark only while it and every digit above it hold the zero glyph.
    always_comb begin
        logic above_zero;
        dark       = '0;
        above_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            above_zero = above_zero && (active_q[k] == SEG_ZERO);
            dark[k]    = above_zero;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            display_pkg::BLANK: if (cnt == CNT_W'(BLANK - 1)) state_d = display_pkg::SHOW;
            display_pkg::SHOW:  if (slot_end)                 state_d = display_pkg::BLANK;
            default:                                          state_d = display_pkg::BLANK;
        endcase

        // Outputs are decoded from the next state so they change on the same edge as the state.
        sel_d = '0;
        seg_d = SEG_OFF;
        if (state_d == display_pkg::SHOW) begin
            sel_d = digit_onehot(idx);
`ifdef ZERO_BLANK_EN
            seg_d = dark[idx] ? SEG_OFF : active_q[idx];
`else
            seg_d = active_q[idx];
`endif
        end

        ack_d        = frame_end && pend_q;
        frame_done_d = frame_end;
    end

    // Commit reads the old pending value; a coincident load refills pending and keeps pend set.
    always_comb begin
        commit    = frame_end && pend_q;
        active_d  = active_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        if (commit) begin
            active_d = pending_q;
            pend_d   = 1'b0;
        end
        if (bus.load) begin
            pending_d = {bus.disp3, bus.disp2, bus.disp1, bus.disp0};
            pend_d    = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= display_pkg::BLANK;
            active_q     <= '0;
            pending_q    <= '0;
            pend_q       <= 1'b0;
            seg_q        <= SEG_OFF;
            sel_q        <= '0;
            ack_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_q       <= pend_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
            ack_q        <= ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.digit_sel  = sel_q;
    assign bus.ack        = ack_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with DIV=8, BLANK=2; honours ZERO_BLANK_EN when defined.
module tb_display_scan_controller;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    display_scan_controller_if bus ();

    display_scan_controller #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .Clock  (clk),
        .Resetn (rstn),
        .bus    (bus)
    );

    typedef struct {
        logic [27:0] disp;
        int          load_off;
        logic [27:0] shown;
    } vec_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          ack_cnt = 0;
    int          last_ack = 0;
    int          fd_cnt = 0;
    int          last_fd = 0;
    logic        pend_m;
    logic [6:0]  act_m [4];
    logic [6:0]  seen [4];
    logic [27:0] sb_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int i);
        bit all_zero;
        all_zero = 1'b1;
`ifdef ZERO_BLANK_EN
        if (i > 0) begin
            for (int k = i; k < 4; k++) if (act_m[k] != 7'h7E) all_zero = 1'b0;
            if (all_zero) return 7'h00;
        end
`endif
        return act_m[i];
    endfunction

    task automatic clear_seen();
        for (int i = 0; i < 4; i++) seen[i] = 'x;
    endtask

    task automatic clear_model();
        cyc      = 0;
        pend_m   = 1'b0;
        last_fd  = 0;
        last_ack = 0;
        sb_q.delete();
        for (int i = 0; i < 4; i++) act_m[i] = 7'h00;
    endtask

    // One clock edge: drive inputs, advance the reference model, then check every output.
    task automatic tick(input logic ld, input logic [27:0] d);
        int          e, cnt_e, idx_e;
        logic        frame, commit;
        logic [27:0] c;
        logic [3:0]  esel;
        logic [6:0]  eseg;
        bus.load = ld;
        {bus.disp3, bus.disp2, bus.disp1, bus.disp0} = d;
        @(posedge clk);
        cyc++;
        e      = cyc;
        frame  = (e % FRAME == 0);
        commit = frame && pend_m;
        if (commit) begin
            c = sb_q.pop_front();
            {act_m[3], act_m[2], act_m[1], act_m[0]} = c;
        end
        if (ld) begin
            if (pend_m && !commit) sb_q[sb_q.size() - 1] = d;
            else                   sb_q.push_back(d);
            pend_m = 1'b1;
        end else if (commit) begin
            pend_m = 1'b0;
        end
        #1;
        cnt_e = e % DIV;
        idx_e = (e / DIV) % 4;
        esel  = (cnt_e >= BLANK) ? (4'b0001 << idx_e) : 4'b0000;
        eseg  = (cnt_e >= BLANK) ? exp_seg(idx_e) : 7'h00;
        chk("digit_sel", 32'(bus.digit_sel), 32'(esel));
        chk("seg", 32'(bus.seg), 32'(eseg));
        chk("ack", 32'(bus.ack), 32'(commit));
        chk("frame_done", 32'(bus.frame_done), 32'(frame));
        if (bus.ack) begin
            ack_cnt++;
            last_ack = e;
        end
        if (bus.frame_done) begin
            if (last_fd != 0) chk("frame_done period", 32'(e - last_fd), 32'(FRAME));
            last_fd = e;
            fd_cnt++;
        end
        if (esel != 4'b0000 && bus.digit_sel == esel) seen[idx_e] = bus.seg;
        bus.load = 1'b0;
    endtask

    task automatic run_to(input int off);
        while (cyc % FRAME != off) tick(1'b0, 28'h0);
    endtask

    task automatic watch_frame();
        clear_seen();
        repeat (FRAME) tick(1'b0, 28'h0);
    endtask

    initial begin
        vec_t        vt [5];
        logic [27:0] va, vb;
        int          acks0, a1, fd0;

        vt[0] = '{ {7'h66, 7'h4F, 7'h5B, 7'h06}, 3,  {7'h66, 7'h4F, 7'h5B, 7'h06} };
`ifdef ZERO_BLANK_EN
        vt[1] = '{ {7'h7E, 7'h7E, 7'h06, 7'h7E}, 9,  {7'h00, 7'h00, 7'h06, 7'h7E} };
        vt[2] = '{ {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 17, {7'h00, 7'h00, 7'h00, 7'h7E} };
        vt[4] = '{ {7'h7E, 7'h06, 7'h7E, 7'h7E}, 30, {7'h00, 7'h06, 7'h7E, 7'h7E} };
`else
        vt[1] = '{ {7'h7E, 7'h7E, 7'h06, 7'h7E}, 9,  {7'h7E, 7'h7E, 7'h06, 7'h7E} };
        vt[2] = '{ {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 17, {7'h7E, 7'h7E, 7'h7E, 7'h7E} };
        vt[4] = '{ {7'h7E, 7'h06, 7'h7E, 7'h7E}, 30, {7'h7E, 7'h06, 7'h7E, 7'h7E} };
`endif
        vt[3] = '{ {7'h7F, 7'h7E, 7'h7E, 7'h6D}, 25, {7'h7F, 7'h7E, 7'h7E, 7'h6D} };

        bus.load = 1'b0;
        {bus.disp3, bus.disp2, bus.disp1, bus.disp0} = 28'h0;
        rstn = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset digit_sel", 32'(bus.digit_sel), 32'h0);
        chk("reset seg", 32'(bus.seg), 32'h0);
        chk("reset ack", 32'(bus.ack), 32'h0);
        chk("reset frame_done", 32'(bus.frame_done), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Table: one load per vector, then watch the frame after its commit.
        for (int i = 0; i < 5; i++) begin
            acks0 = ack_cnt;
            run_to(vt[i].load_off);
            tick(1'b1, vt[i].disp);
            run_to(0);
            if (i == 0) chk("first ack cycle", 32'(last_ack), 32'd32);
            watch_frame();
            chk("shown frame", {seen[3], seen[2], seen[1], seen[0]}, 32'(vt[i].shown));
            chk("acks per load", 32'(ack_cnt - acks0), 32'd1);
        end

        // Two loads inside one frame: last one wins with a single ack.
        va = {7'h06, 7'h06, 7'h06, 7'h06};
        vb = {7'h5B, 7'h4F, 7'h66, 7'h6D};
        acks0 = ack_cnt;
        run_to(2);
        tick(1'b1, va);
        run_to(10);
        tick(1'b1, vb);
        run_to(0);
        watch_frame();
        chk("double load ack count", 32'(ack_cnt - acks0), 32'd1);
        chk("double load shows B", {seen[3], seen[2], seen[1], seen[0]}, 32'(vb));

        // Load on the commit edge: old pending commits now, new one a frame later.
        va = {7'h30, 7'h6D, 7'h79, 7'h5E};
        vb = {7'h07, 7'h7F, 7'h6F, 7'h77};
        acks0 = ack_cnt;
        run_to(5);
        tick(1'b1, va);
        run_to(FRAME - 1);
        tick(1'b1, vb);
        chk("ack on load+commit edge", 32'(bus.ack), 32'd1);
        a1 = last_ack;
        watch_frame();
        chk("collision shows A", {seen[3], seen[2], seen[1], seen[0]}, 32'(va));
        chk("second ack spacing", 32'(last_ack - a1), 32'(FRAME));
        watch_frame();
        chk("collision then shows B", {seen[3], seen[2], seen[1], seen[0]}, 32'(vb));
        chk("collision ack count", 32'(ack_cnt - acks0), 32'd2);

        // Asynchronous reset in the middle of digit 2's lit interval.
        run_to(2 * DIV + 4);
        chk("digit 2 lit before reset", 32'(bus.digit_sel), 32'h4);
        #2 rstn = 1'b0;
        #1;
        chk("async reset digit_sel", 32'(bus.digit_sel), 32'h0);
        chk("async reset seg", 32'(bus.seg), 32'h0);
        chk("async reset ack", 32'(bus.ack), 32'h0);
        chk("async reset frame_done", 32'(bus.frame_done), 32'h0);
        @(posedge clk);
        #1;
        chk("held reset digit_sel", 32'(bus.digit_sel), 32'h0);
        @(negedge clk);
        clear_model();
        rstn = 1'b1;
        watch_frame();
        chk("active cleared by reset", {seen[3], seen[2], seen[1], seen[0]}, 32'h0);

        // frame_done cadence: ten quiet frames, then ten with random loads.
        fd0 = fd_cnt;
        repeat (10 * FRAME) tick(1'b0, 28'h0);
        repeat (10 * FRAME) tick($urandom_range(0, 7) == 0, 28'($urandom()));
        chk("frame_done pulse count", 32'(fd_cnt - fd0), 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
